rf_write_arbiter: RTL and testbench

Shares the single write port of the 32 x 32-bit register file between two writeback requesters: requester 0 (ALU result) and requester 1 (load data from memory). It arbitrates round-robin and buffers the winning write in a one-entry output slot that drives the register file's `writereg`/`rd`/`writedata` inputs. It absorbs a downstream `hold` (pipeline freeze) and publishes a pending-write mask that decode uses for hazard checks. It sits between the execute/memory stages and the register file.

---
 rtl/rf_write_arbiter.sv | 87 ++++++++
 tb/tb_rf_write_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (req0)
// and load (req1) writeback paths, with a one-entry output slot that absorbs hold.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic [ADDR_W-1:0]      req0_rd,
    input  logic [DATA_W-1:0]      req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [ADDR_W-1:0]      req1_rd,
    input  logic [DATA_W-1:0]      req1_data,
    output logic                   req1_ready,
    input  logic                   hold,
    output logic                   writereg,
    output logic [ADDR_W-1:0]      rd,
    output logic [DATA_W-1:0]      writedata,
    output logic [(1<<ADDR_W)-1:0] pending_mask,
    output logic                   last_grant
);

    typedef enum logic {P0 = 1'b0, P1 = 1'b1} prio_t;

    prio_t               prio;
    logic                slot_valid;
    logic [ADDR_W-1:0]   slot_rd;
    logic [DATA_W-1:0]   slot_data;

    logic                can_accept;
    logic                grant0;
    logic                grant1;
    logic                xfer;
    logic [ADDR_W-1:0]   win_rd;
    logic [DATA_W-1:0]   win_data;

    // Slot is empty or draining this cycle, so a new write can land behind it.
    assign can_accept = !slot_valid || !hold;

    assign grant0 = req0_valid && (!req1_valid || (prio == P0));
    assign grant1 = req1_valid && (!req0_valid || (prio == P1));

    // Readies are forced low while reset is asserted so nothing is consumed.
    assign req0_ready = grant0 && can_accept && reset;
    assign req1_ready = grant1 && can_accept && reset;

    assign xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign win_rd   = grant1 ? req1_rd   : req0_rd;
    assign win_data = grant1 ? req1_data : req0_data;

    assign writereg  = slot_valid && !hold;
    assign rd        = slot_rd;
    assign writedata = slot_data;

    always_comb begin
        pending_mask = '0;
        if (slot_valid) begin
            pending_mask[slot_rd] = 1'b1;
        end
    end

    // Slot / priority update; writes to x0 are consumed without occupying the slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid <= 1'b0;
            slot_rd    <= '0;
            slot_data  <= '0;
            prio       <= P0;
            last_grant <= 1'b0;
        end else begin
            if (xfer) begin
                prio       <= grant1 ? P0 : P1;
                last_grant <= grant1;
            end
            if (xfer && (win_rd != '0)) begin
                slot_valid <= 1'b1;
                slot_rd    <= win_rd;
                slot_data  <= win_data;
            end else if (writereg) begin
                slot_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: per-cycle vector table with a write scoreboard,
// plus a hand-written reset-during-pending-write sequence.
module tb_rf_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0, hold = 1'b0;
    logic [ADDR_W-1:0] req0_rd = '0, req1_rd = '0;
    logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
    logic              req0_ready, req1_ready, writereg, last_grant;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] writedata;
    logic [31:0]       pending_mask;

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .hold(hold), .writereg(writereg), .rd(rd), .writedata(writedata),
        .pending_mask(pending_mask), .last_grant(last_grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        r0v;
        logic [4:0]  r0rd;
        logic [31:0] r0d;
        logic        r1v;
        logic [4:0]  r1rd;
        logic [31:0] r1d;
        logic        hld;
        logic        e0;
        logic        e1;
        logic        ewr;
        logic [31:0] epm;
        logic        elg;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   tests = 0;
    int   fails = 0;

    // Register file model built from what the DUT actually writes.
    logic [31:0] regs  [32];
    logic        wrote [32];
    initial for (int i = 0; i < 32; i++) begin regs[i] = '0; wrote[i] = 1'b0; end
    always @(posedge clock) if (writereg) begin regs[rd] <= writedata; wrote[rd] <= 1'b1; end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0v, input logic [4:0] r0rd, input logic [31:0] r0d,
                       input logic r1v, input logic [4:0] r1rd, input logic [31:0] r1d,
                       input logic hld, input logic e0, input logic e1, input logic ewr,
                       input logic [31:0] epm, input logic elg);
        vec_t v;
        v.r0v = r0v; v.r0rd = r0rd; v.r0d = r0d;
        v.r1v = r1v; v.r1rd = r1rd; v.r1d = r1d;
        v.hld = hld; v.e0 = e0; v.e1 = e1; v.ewr = ewr; v.epm = epm; v.elg = elg;
        vecs.push_back(v);
    endtask

    // Pop the oldest expected write whenever the DUT presents one.
    task automatic check_write(input string tag);
        wr_t w;
        if (writereg) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected write rd"}, 64'(rd), 64'hFFFF);
            end else begin
                w = sb.pop_front();
                chk({tag, " write rd"}, 64'(rd), 64'(w.rd));
                chk({tag, " write data"}, 64'(writedata), 64'(w.data));
            end
        end
    endtask

    initial begin
        // Single write, x0 drop, round robin, hold while full, same-rd, hold while empty.
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,         0, 1, 0, 0, 32'h0,   0);
        add(0, 0, 0,            0, 0, 0,         0, 0, 0, 1, 32'h20,  0);
        add(0, 0, 0,            1, 0, 32'h1234,  0, 0, 1, 0, 32'h0,   0);
        add(0, 0, 0,            0, 0, 0,         0, 0, 0, 0, 32'h0,   1);
        add(1, 1, 32'hA1,       1, 9,  32'hB9,   0, 1, 0, 0, 32'h0,   1);
        add(1, 2, 32'hA2,       1, 9,  32'hB9,   0, 0, 1, 1, 32'h2,   0);
        add(1, 2, 32'hA2,       1, 10, 32'hB10,  0, 1, 0, 1, 32'h200, 1);
        add(1, 3, 32'hA3,       1, 10, 32'hB10,  0, 0, 1, 1, 32'h4,   0);
        add(1, 3, 32'hA3,       1, 11, 32'hB11,  0, 1, 0, 1, 32'h400, 1);
        add(0, 0, 0,            1, 11, 32'hB11,  0, 0, 1, 1, 32'h8,   0);
        add(0, 0, 0,            0, 0, 0,         0, 0, 0, 1, 32'h800, 1);
        add(1, 7, 32'hC7,       0, 0, 0,         0, 1, 0, 0, 32'h0,   1);
        add(1, 8, 32'hC8,       0, 0, 0,         1, 0, 0, 0, 32'h80,  0);
        add(1, 8, 32'hC8,       0, 0, 0,         1, 0, 0, 0, 32'h80,  0);
        add(1, 8, 32'hC8,       0, 0, 0,         1, 0, 0, 0, 32'h80,  0);
        add(1, 8, 32'hC8,       0, 0, 0,         0, 1, 0, 1, 32'h80,  0);
        add(0, 0, 0,            0, 0, 0,         0, 0, 0, 1, 32'h100, 0);
        add(1, 4, 32'hA,        1, 4, 32'hB,     0, 0, 1, 0, 32'h0,   0);
        add(1, 4, 32'hA,        0, 0, 0,         0, 1, 0, 1, 32'h10,  1);
        add(0, 0, 0,            0, 0, 0,         0, 0, 0, 1, 32'h10,  0);
        add(0, 0, 0,            1, 6, 32'hD6,    1, 0, 1, 0, 32'h0,   0);
        add(0, 0, 0,            0, 0, 0,         1, 0, 0, 0, 32'h40,  1);
        add(0, 0, 0,            0, 0, 0,         0, 0, 0, 1, 32'h40,  1);

        // Reset state, with requests already asserted.
        req0_valid = 1'b1; req0_rd = 5'd2; req1_valid = 1'b1; req1_rd = 5'd3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset writereg", 64'(writereg), 64'd0);
        chk("reset rd", 64'(rd), 64'd0);
        chk("reset writedata", 64'(writedata), 64'd0);
        chk("reset pending_mask", 64'(pending_mask), 64'd0);
        chk("reset last_grant", 64'(last_grant), 64'd0);
        chk("reset ready0", 64'(req0_ready), 64'd0);
        chk("reset ready1", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(posedge clock); #1;
            req0_valid = vecs[i].r0v; req0_rd = vecs[i].r0rd; req0_data = vecs[i].r0d;
            req1_valid = vecs[i].r1v; req1_rd = vecs[i].r1rd; req1_data = vecs[i].r1d;
            hold = vecs[i].hld;
            @(negedge clock);
            chk({tag, " req0_ready"}, 64'(req0_ready), 64'(vecs[i].e0));
            chk({tag, " req1_ready"}, 64'(req1_ready), 64'(vecs[i].e1));
            chk({tag, " writereg"}, 64'(writereg), 64'(vecs[i].ewr));
            chk({tag, " pending_mask"}, 64'(pending_mask), 64'(vecs[i].epm));
            chk({tag, " last_grant"}, 64'(last_grant), 64'(vecs[i].elg));
            check_write(tag);
            if (vecs[i].e0 && vecs[i].r0v && vecs[i].r0rd != 0)
                sb.push_back('{rd: vecs[i].r0rd, data: vecs[i].r0d});
            if (vecs[i].e1 && vecs[i].r1v && vecs[i].r1rd != 0)
                sb.push_back('{rd: vecs[i].r1rd, data: vecs[i].r1d});
        end

        // Reset while the slot holds a write to x3: the write must never issue.
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hE3; hold = 1'b0;
        @(negedge clock);
        chk("midrst ready0", 64'(req0_ready), 64'd1);
        check_write("midrst pre");
        @(posedge clock); #1;
        req0_valid = 1'b0;
        chk("midrst slot pending", 64'(pending_mask), 64'h8);
        reset = 1'b0;
        #1;
        chk("midrst writereg", 64'(writereg), 64'd0);
        chk("midrst pending_mask", 64'(pending_mask), 64'd0);
        chk("midrst rd", 64'(rd), 64'd0);
        chk("midrst last_grant", 64'(last_grant), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post-reset writereg", 64'(writereg), 64'd0);
            check_write("post-reset");
        end

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        chk("reg5 final", 64'(regs[5]), 64'hDEADBEEF);
        chk("reg4 final", 64'(regs[4]), 64'hA);
        chk("reg11 final", 64'(regs[11]), 64'hB11);
        chk("reg3 final", 64'(regs[3]), 64'hA3);
        chk("reg0 never written", 64'(wrote[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
